// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: key-size legality, NK/NR/NW
// derivation, xtime, initial round constant and the FSM state encoding.
package aes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    localparam logic [7:0] RCON_INIT = 8'h01;

    function automatic bit key_bits_ok(input int kb);
        return (kb == 128) || (kb == 192) || (kb == 256);
    endfunction

    function automatic int calc_nk(input int kb);
        return kb / 32;
    endfunction

    function automatic int calc_nr(input int nk);
        return nk + 6;
    endfunction

    function automatic int calc_nw(input int nr);
        return 4 * (nr + 1);
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_key_schedule_seq_sbox.sv
// AES forward S-box, one byte, purely combinational table lookup.
// Ports: i_byte (input byte), o_byte (substituted byte).
module aes_key_schedule_seq_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign o_byte = SBOX[i_byte];

endmodule

// File: rtl/aes_key_schedule_seq.sv
// Sequential AES-128/192/256 key expansion: one 32-bit schedule word per
// cycle into a word store, with a registered 128-bit round-key read port.
// Ports: clk, rst (async, active-high); key_in/key_valid/key_ready load
// handshake; busy (expanding), done (last-word pulse); rd_en/rd_round
// request, rd_key/rd_valid response one cycle later.
module aes_key_schedule_seq
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [KEY_BITS-1:0] key_in,
    input  logic                key_valid,
    output logic                key_ready,
    output logic                busy,
    output logic                done,
    input  logic                rd_en,
    input  logic [3:0]          rd_round,
    output logic [127:0]        rd_key,
    output logic                rd_valid
);

    localparam int NK = calc_nk(KEY_BITS);
    localparam int NR = calc_nr(NK);
    localparam int NW = calc_nw(NR);
    localparam int PW = $clog2(NW + 1);

    if (!key_bits_ok(KEY_BITS)) begin : g_bad_key_bits
        $error("aes_key_schedule_seq: KEY_BITS must be 128, 192 or 256");
    end

    state_e        r_state;
    state_e        w_next;
    logic [31:0]   r_w [NW];
    logic [PW-1:0] r_wr_ptr;
    logic [2:0]    r_k;
    logic [7:0]    r_rcon;
    logic          r_done;
    logic          r_rd_valid;
    logic [127:0]  r_rd_key;

    logic          w_load;
    logic          w_expand;
    logic          w_last;
    logic [31:0]   w_prev;
    logic [31:0]   w_back;
    logic [31:0]   w_sub_in;
    logic [31:0]   w_sub;
    logic [31:0]   w_temp;
    logic [31:0]   w_new;
    logic          w_rd_ok;
    logic [PW-1:0] w_rd_base;
    logic [PW-1:0] w_rd_top;

    assign w_load   = key_valid && key_ready;
    assign w_expand = (r_state == ST_EXPAND);
    assign w_last   = w_expand && (r_wr_ptr == PW'(NW - 1));

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:   if (w_load) w_next = ST_EXPAND;
            ST_EXPAND: if (w_last) w_next = ST_DONE;
            ST_DONE:   if (w_load) w_next = ST_EXPAND;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        key_ready = 1'b1;
        busy      = 1'b0;
        unique case (r_state)
            ST_EXPAND: begin
                key_ready = 1'b0;
                busy      = 1'b1;
            end
            default: begin
                key_ready = 1'b1;
                busy      = 1'b0;
            end
        endcase
    end

    // ---------------- word generation ----------------
    assign w_prev   = r_w[r_wr_ptr - PW'(1)];
    assign w_back   = r_w[r_wr_ptr - PW'(NK)];
    // RotWord only on the first word of each NK-word group
    assign w_sub_in = (r_k == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

    for (genvar g = 0; g < 4; g++) begin : g_subword
        aes_key_schedule_seq_sbox u_sbox (
            .i_byte (w_sub_in[8*g +: 8]),
            .o_byte (w_sub[8*g +: 8])
        );
    end

    always_comb begin
        w_temp = w_prev;
        if (r_k == 3'd0) begin
            w_temp = w_sub ^ {r_rcon, 24'h0};
        end else if (NK == 8 && r_k == 3'd4) begin
            // extra SubWord in the middle of each AES-256 group
            w_temp = w_sub;
        end
    end

    assign w_new = w_back ^ w_temp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_k      <= '0;
            r_rcon   <= RCON_INIT;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_load) begin
                r_wr_ptr <= PW'(NK);
                r_k      <= '0;
                r_rcon   <= RCON_INIT;
            end else if (w_expand) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
                r_k      <= (r_k == 3'(NK - 1)) ? 3'd0 : r_k + 3'd1;
                if (r_k == 3'd0) begin
                    r_rcon <= xtime(r_rcon);
                end
            end
        end
    end

    // Store contents are don't-care after reset, so no reset here
    always_ff @(posedge clk) begin
        if (w_load) begin
            for (int j = 0; j < NK; j++) begin
                r_w[j] <= key_in[KEY_BITS-1-32*j -: 32];
            end
        end else if (w_expand) begin
            r_w[r_wr_ptr] <= w_new;
        end
    end

    // ---------------- read port ----------------
    // Compared against the pre-load pointer, so a read coinciding with a
    // reload still returns the old key's words.
    assign w_rd_base = PW'({rd_round, 2'b00});
    assign w_rd_top  = w_rd_base | PW'(3);
    assign w_rd_ok   = rd_en && (rd_round <= 4'(NR)) && (w_rd_top < r_wr_ptr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_key   <= '0;
        end else begin
            r_rd_valid <= w_rd_ok;
            if (w_rd_ok) begin
                r_rd_key <= {r_w[w_rd_base],
                             r_w[w_rd_base + PW'(1)],
                             r_w[w_rd_base + PW'(2)],
                             r_w[w_rd_base + PW'(3)]};
            end
        end
    end

    assign done     = r_done;
    assign rd_key   = r_rd_key;
    assign rd_valid = r_rd_valid;

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Directed bench for aes_key_schedule_seq: one instance per key size,
// FIPS-197 vectors, mid-expansion reads, reload and reset cases.
module tb_aes_key_schedule_seq;

    localparam logic [127:0] KEY1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KEY2   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [191:0] KEY3   =
        192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [127:0] K3_R0  = 128'h8e73b0f7da0e6452c810f32b809079e5;
    localparam logic [127:0] K3_R12 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [255:0] KEY4   =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] K4_R1  = 128'h1f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] K4_R14 = 128'hfe4890d1e6188d0b046df344706c631e;

    logic         clk;
    logic         rst;
    logic         rd_en;
    logic [3:0]   rd_round;

    logic [127:0] a_key;
    logic         a_kv, a_kr, a_busy, a_done, a_rv;
    logic [127:0] a_rk;
    logic [191:0] b_key;
    logic         b_kv, b_kr, b_busy, b_done, b_rv;
    logic [127:0] b_rk;
    logic [255:0] c_key;
    logic         c_kv, c_kr, c_busy, c_done, c_rv;
    logic [127:0] c_rk;

    int checks = 0;
    int errors = 0;

    aes_key_schedule_seq #(.KEY_BITS(128)) u_a (
        .clk(clk), .rst(rst), .key_in(a_key), .key_valid(a_kv),
        .key_ready(a_kr), .busy(a_busy), .done(a_done),
        .rd_en(rd_en), .rd_round(rd_round), .rd_key(a_rk), .rd_valid(a_rv)
    );

    aes_key_schedule_seq #(.KEY_BITS(192)) u_b (
        .clk(clk), .rst(rst), .key_in(b_key), .key_valid(b_kv),
        .key_ready(b_kr), .busy(b_busy), .done(b_done),
        .rd_en(rd_en), .rd_round(rd_round), .rd_key(b_rk), .rd_valid(b_rv)
    );

    aes_key_schedule_seq #(.KEY_BITS(256)) u_c (
        .clk(clk), .rst(rst), .key_in(c_key), .key_valid(c_kv),
        .key_ready(c_kr), .busy(c_busy), .done(c_done),
        .rd_en(rd_en), .rd_round(rd_round), .rd_key(c_rk), .rd_valid(c_rv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic pick_done(input int which);
        case (which)
            0:       return a_done;
            1:       return b_done;
            default: return c_done;
        endcase
    endfunction

    // Counts edges until done; a timeout shows up as a count mismatch.
    task automatic wait_done(input int which, input int exp_n, input string tag);
        int  n;
        logic seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            tick();
            n++;
            seen = pick_done(which);
        end
        check(tag, 128'(n), 128'(exp_n));
    endtask

    task automatic rd(input logic [3:0] r);
        rd_en    = 1'b1;
        rd_round = r;
        tick();
        rd_en    = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rd_en = 1'b0; rd_round = '0;
        a_key = '0; a_kv = 1'b0;
        b_key = '0; b_kv = 1'b0;
        c_key = '0; c_kv = 1'b0;
        tick();
        tick();
        check("rst_key_ready", 128'(a_kr), 128'(1));
        check("rst_busy",      128'(a_busy), 128'(0));
        check("rst_done",      128'(a_done), 128'(0));
        check("rst_rd_key",    a_rk, 128'h0);
        check("rst_rd_valid",  128'(a_rv), 128'(0));
        rst = 1'b0;
        tick();

        // AES-128 full expansion
        a_key = KEY1; a_kv = 1'b1;
        tick();
        a_kv = 1'b0;
        check("t1_busy_after_load",  128'(a_busy), 128'(1));
        check("t1_ready_after_load", 128'(a_kr), 128'(0));
        wait_done(0, 40, "t1_done_cycles");
        check("t1_ready_in_done", 128'(a_kr), 128'(1));
        check("t1_busy_in_done",  128'(a_busy), 128'(0));
        tick();
        check("t1_done_pulse", 128'(a_done), 128'(0));
        rd(4'd0);
        check("t1_r0_valid", 128'(a_rv), 128'(1));
        check("t1_r0_key", a_rk, KEY1);
        rd(4'd1);
        check("t1_r1_key", a_rk, K1_R1);
        rd(4'd10);
        check("t1_r10_valid", 128'(a_rv), 128'(1));
        check("t1_r10_key", a_rk, K1_R10);
        rd(4'd11);
        check("t1_r11_valid", 128'(a_rv), 128'(0));
        check("t1_r11_hold", a_rk, K1_R10);

        // reload in DONE with a simultaneous read of the old schedule
        a_key = KEY2; a_kv = 1'b1;
        rd(4'd10);
        a_kv = 1'b0;
        check("reload_rd_valid", 128'(a_rv), 128'(1));
        check("reload_rd_old", a_rk, K1_R10);
        check("reload_busy", 128'(a_busy), 128'(1));
        wait_done(0, 40, "reload_done_cycles");
        rd(4'd10);
        check("key2_r10", a_rk, K2_R10);

        // mid-expansion reads (store currently holds KEY2's schedule)
        a_key = KEY1; a_kv = 1'b1;
        tick();
        a_kv = 1'b0;
        rd(4'd0);
        check("mid_r0_valid", 128'(a_rv), 128'(1));
        check("mid_r0_key", a_rk, KEY1);
        rd(4'd1);
        check("mid_r1_early", 128'(a_rv), 128'(0));
        tick();
        tick();
        rd(4'd1);
        check("mid_r1_valid", 128'(a_rv), 128'(1));
        check("mid_r1_key", a_rk, K1_R1);
        rd(4'd10);
        check("mid_r10_valid", 128'(a_rv), 128'(0));
        check("mid_r10_hold", a_rk, K1_R1);
        rd(4'd11);
        check("mid_r11_valid", 128'(a_rv), 128'(0));
        wait_done(0, 33, "mid_done_cycles");

        // key_valid held through EXPAND with a changing key_in
        a_key = KEY2; a_kv = 1'b1;
        tick();
        a_key = KEY1;
        tick();
        tick();
        tick();
        check("hold_ready", 128'(a_kr), 128'(0));
        check("hold_busy",  128'(a_busy), 128'(1));
        wait_done(0, 37, "hold_done_cycles");
        a_kv = 1'b0;
        rd(4'd10);
        check("hold_r10_key", a_rk, K2_R10);

        // reset in the middle of expansion
        a_key = KEY1; a_kv = 1'b1;
        tick();
        a_kv = 1'b0;
        repeat (19) tick();
        rst = 1'b1;
        #1;
        check("mrst_ready",    128'(a_kr), 128'(1));
        check("mrst_busy",     128'(a_busy), 128'(0));
        check("mrst_done",     128'(a_done), 128'(0));
        check("mrst_rd_key",   a_rk, 128'h0);
        check("mrst_rd_valid", 128'(a_rv), 128'(0));
        tick();
        rst = 1'b0;
        rd(4'd0);
        check("mrst_r0_valid", 128'(a_rv), 128'(0));
        a_kv = 1'b1;
        tick();
        a_kv = 1'b0;
        wait_done(0, 40, "mrst_done_cycles");
        rd(4'd10);
        check("mrst_r10_key", a_rk, K1_R10);

        // AES-192
        b_key = KEY3; b_kv = 1'b1;
        tick();
        b_kv = 1'b0;
        wait_done(1, 46, "k192_done_cycles");
        rd(4'd0);
        check("k192_r0", b_rk, K3_R0);
        rd(4'd12);
        check("k192_r12_valid", 128'(b_rv), 128'(1));
        check("k192_r12", b_rk, K3_R12);
        rd(4'd13);
        check("k192_r13_valid", 128'(b_rv), 128'(0));

        // AES-256
        c_key = KEY4; c_kv = 1'b1;
        tick();
        c_kv = 1'b0;
        wait_done(2, 52, "k256_done_cycles");
        rd(4'd1);
        check("k256_r1", c_rk, K4_R1);
        rd(4'd14);
        check("k256_r14_valid", 128'(c_rv), 128'(1));
        check("k256_r14", c_rk, K4_R14);
        rd(4'd15);
        check("k256_r15_valid", 128'(c_rv), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
